catrec_apb_regs: RTL

APB slave register bank and memory-window decoder for the CatRecognizer. It sits directly downstream of the APB bus bundle: it consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA, drives PRDATA and CatRecOut back onto it, and converts bus transfers into control registers, a start pulse and a write port into the core's image/weight memory. It holds the run state (busy/done/result) between the bus and the compute core.

---
 rtl/catrec_apb_pkg.sv | 31 +++
 rtl/catrec_apb_regs_if.sv | 23 ++
 rtl/catrec_apb_fsm.sv | 35 +++
 rtl/catrec_apb_regs.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/catrec_apb_pkg.sv
// catrec_apb_pkg: shared widths, register map, STATUS bit positions and bus FSM
// state encoding for the CatRecognizer APB register bank.
package catrec_apb_pkg;

    localparam int unsigned AMBA_WORD       = 32;
    localparam int unsigned AMBA_ADDR_DEPTH = 12;
    localparam int unsigned ADDR_W          = AMBA_ADDR_DEPTH + 1;

    localparam logic [AMBA_WORD-1:0] ID_VALUE = 32'hCA70_0001;

    // Register offsets (word addresses)
    localparam logic [ADDR_W-1:0] REG_CTRL    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] REG_STATUS  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] REG_THRESH  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] REG_ID      = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WINDOW_BASE = ADDR_W'(4);

    // CTRL / STATUS bit indices
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;
    localparam int unsigned STAT_RESULT = 2;
    localparam int unsigned STAT_ERR    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/catrec_apb_regs_if.sv
// catrec_apb_regs_if: APB bundle between bus master and the CatRecognizer regs.
interface catrec_apb_regs_if;
    import catrec_apb_pkg::*;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [AMBA_WORD-1:0]  PWDATA;
    logic [AMBA_WORD-1:0]  PRDATA;
    logic                  CatRecOut;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, CatRecOut
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, CatRecOut
    );

endinterface

// File: rtl/catrec_apb_fsm.sv
// catrec_apb_fsm: tracks APB SETUP/ACCESS phases. wr_strobe_c is high during a
// write ACCESS that followed a proper SETUP; rd_setup_c is high during a read
// SETUP. Both are decoded from the phase register and the live bus.
module catrec_apb_fsm
    import catrec_apb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic psel_i,
    input  logic penable_i,
    input  logic pwrite_i,
    output logic wr_strobe_c,
    output logic rd_setup_c
);

    apb_state_e state_q;

    // Phase of the previous cycle; ACCESS is only entered from SETUP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (psel_i && !penable_i) begin
            state_q <= ST_SETUP;
        end else if (psel_i && penable_i && (state_q == ST_SETUP)) begin
            state_q <= ST_ACCESS;
        end else begin
            state_q <= ST_IDLE;
        end
    end

    // PENABLE without a preceding SETUP never produces a strobe
    assign wr_strobe_c = (state_q == ST_SETUP) && psel_i && penable_i && pwrite_i;
    assign rd_setup_c  = psel_i && !penable_i && !pwrite_i;

endmodule

// File: rtl/catrec_apb_regs.sv
// catrec_apb_regs: APB register bank + memory-window decoder for CatRecognizer.
// Optional build macro CATREC_APB_READBACK_EN enables reads of the memory window
// (address presented during SETUP, mem_rdata captured into PRDATA for ACCESS).
module catrec_apb_regs
    import catrec_apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    catrec_apb_regs_if.slave      apb,
    output logic                  core_start,
    output logic [AMBA_WORD-1:0]  core_thresh,
    input  logic                  core_done,
    input  logic                  core_result,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [AMBA_WORD-1:0]  mem_wdata,
    input  logic [AMBA_WORD-1:0]  mem_rdata
);

    logic                 wr_strobe_c, rd_setup_c;
    logic                 is_ctrl_c, is_status_c, is_thresh_c, is_id_c, is_win_c;
    logic                 start_req_c, win_wr_c, done_evt_c;
    logic [ADDR_W-1:0]    win_off_c;
    logic [AMBA_WORD-1:0] status_c;

    logic                 busy_q, busy_d, done_q, done_d;
    logic                 result_q, result_d, err_q, err_d;
    logic                 core_start_q, core_start_d, mem_we_q, mem_we_d;
    logic [AMBA_WORD-1:0] thresh_q, thresh_d, prdata_q, prdata_d;
    logic [AMBA_WORD-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;

    catrec_apb_fsm u_fsm (
        .clk         (clk),
        .rst         (rst),
        .psel_i      (apb.PSEL),
        .penable_i   (apb.PENABLE),
        .pwrite_i    (apb.PWRITE),
        .wr_strobe_c (wr_strobe_c),
        .rd_setup_c  (rd_setup_c)
    );

    // Address decode and event qualification
    always_comb begin
        is_ctrl_c   = (apb.PADDR == REG_CTRL);
        is_status_c = (apb.PADDR == REG_STATUS);
        is_thresh_c = (apb.PADDR == REG_THRESH);
        is_id_c     = (apb.PADDR == REG_ID);
        is_win_c    = (apb.PADDR >= WINDOW_BASE);
        win_off_c   = apb.PADDR - WINDOW_BASE;
        start_req_c = wr_strobe_c && is_ctrl_c && apb.PWDATA[CTRL_START];
        win_wr_c    = wr_strobe_c && is_win_c;
        done_evt_c  = core_done && busy_q;
        status_c              = '0;
        status_c[STAT_BUSY]   = busy_q;
        status_c[STAT_DONE]   = done_q;
        status_c[STAT_RESULT] = result_q;
        status_c[STAT_ERR]    = err_q;
    end

    // Register next-state; core_done is applied last so its DONE set beats a W1C
    always_comb begin
        busy_d       = busy_q;
        done_d       = done_q;
        result_d     = result_q;
        err_d        = err_q;
        thresh_d     = thresh_q;
        core_start_d = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (wr_strobe_c && is_status_c) begin
            if (apb.PWDATA[STAT_DONE]) done_d = 1'b0;
            if (apb.PWDATA[STAT_ERR])  err_d  = 1'b0;
        end
        if (wr_strobe_c && is_thresh_c) thresh_d = apb.PWDATA;

        // A START or window write during a run is refused and flagged
        if ((start_req_c || win_wr_c) && busy_q) err_d = 1'b1;

        if (start_req_c && !busy_q) begin
            busy_d       = 1'b1;
            done_d       = 1'b0;
            core_start_d = 1'b1;
        end
        if (win_wr_c && !busy_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = win_off_c;
            mem_wdata_d = apb.PWDATA;
        end
        if (done_evt_c) begin
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = core_result;
        end
    end

    // Read data is selected during SETUP and presented for ACCESS, else zero
    always_comb begin
        prdata_d = '0;
        if (rd_setup_c) begin
            if (is_status_c)      prdata_d = status_c;
            else if (is_thresh_c) prdata_d = thresh_q;
            else if (is_id_c)     prdata_d = ID_VALUE;
`ifdef CATREC_APB_READBACK_EN
            else if (is_win_c)    prdata_d = mem_rdata;
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= 1'b0;
            err_q        <= 1'b0;
            thresh_q     <= '0;
            prdata_q     <= '0;
            core_start_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            err_q        <= err_d;
            thresh_q     <= thresh_d;
            prdata_q     <= prdata_d;
            core_start_q <= core_start_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign apb.PRDATA    = prdata_q;
    assign apb.CatRecOut = result_q;
    assign core_start    = core_start_q;
    assign core_thresh   = thresh_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;

`ifdef CATREC_APB_READBACK_EN
    // Window reads present their address while in SETUP
    assign mem_addr = (rd_setup_c && is_win_c) ? win_off_c : mem_addr_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mem_addr     = mem_addr_q;
`endif

endmodule
